// File: rtl/move_input_ctrl.sv
// Board direction buttons -> synchronised, debounced, rate-limited one-cycle move requests.
// Optional feature macro MOVE_AUTOREPEAT_EN: auto-repeat while held (otherwise one pulse per press).
module move_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000,
  parameter int CNT_W           = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_left,
  input  logic btn_right,
  input  logic gamerun,
  output logic up,
  output logic down,
  output logic left,
  output logic right,
  output logic any_held
);

  localparam int NB = 4;
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef MOVE_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);
`endif

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2 || CNT_W < 1 || CNT_W > 31)
  begin : g_param_check
    $error("move_input_ctrl: invalid parameter set");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK   = 2'd1
`ifdef MOVE_AUTOREPEAT_EN
    ,
    DELAY  = 2'd2,
    REPEAT = 2'd3
`endif
  } state_e;

  logic [NB-1:0]    raw;
  logic [NB-1:0]    s1_q, s2_q;
  logic [NB-1:0]    stable_q, stable_d;
  logic [CNT_W-1:0] dcnt_q [NB];
  logic [CNT_W-1:0] dcnt_d [NB];
  state_e           st_q [NB];
  state_e           st_d [NB];
  logic [NB-1:0]    due;
  logic [NB-1:0]    pulse_q, pulse_d;
`ifdef MOVE_AUTOREPEAT_EN
  logic [CNT_W-1:0] rcnt_q [NB];
  logic [CNT_W-1:0] rcnt_d [NB];
`endif

  // Bit order everywhere: 0=up, 1=down, 2=left, 3=right.
  assign raw = {btn_right, btn_left, btn_down, btn_up};

  always_comb begin
    for (int i = 0; i < NB; i++) begin
      stable_d[i] = stable_q[i];
      dcnt_d[i]   = '0;
      if (s2_q[i] != stable_q[i]) begin
        if (dcnt_q[i] == DB_LAST) stable_d[i] = s2_q[i];
        else                      dcnt_d[i]   = dcnt_q[i] + ONE;
      end
    end
  end

  // Release always wins; a stop in play while held parks the button in LOCK until release.
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      st_d[i] = st_q[i];
      due[i]  = 1'b0;
`ifdef MOVE_AUTOREPEAT_EN
      rcnt_d[i] = rcnt_q[i];
`endif
      if (!stable_q[i]) begin
        st_d[i] = IDLE;
      end else if (!gamerun) begin
        st_d[i] = LOCK;
      end else begin
        case (st_q[i])
          IDLE: begin
            due[i] = 1'b1;
`ifdef MOVE_AUTOREPEAT_EN
            rcnt_d[i] = '0;
            st_d[i]   = DELAY;
`else
            st_d[i]   = LOCK;
`endif
          end
`ifdef MOVE_AUTOREPEAT_EN
          DELAY: begin
            if (rcnt_q[i] == RD_LAST) begin
              due[i]    = 1'b1;
              rcnt_d[i] = '0;
              st_d[i]   = REPEAT;
            end else begin
              rcnt_d[i] = rcnt_q[i] + ONE;
            end
          end
          REPEAT: begin
            if (rcnt_q[i] == RP_LAST) begin
              due[i]    = 1'b1;
              rcnt_d[i] = '0;
            end else begin
              rcnt_d[i] = rcnt_q[i] + ONE;
            end
          end
`endif
          LOCK:    st_d[i] = LOCK;
          default: st_d[i] = IDLE;
        endcase
      end
    end
  end

  // Opposing directions cancel; orthogonal ones pass together.
  always_comb begin
    pulse_d[0] = due[0] & ~due[1];
    pulse_d[1] = due[1] & ~due[0];
    pulse_d[2] = due[2] & ~due[3];
    pulse_d[3] = due[3] & ~due[2];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      stable_q <= '0;
      pulse_q  <= '0;
      for (int i = 0; i < NB; i++) begin
        dcnt_q[i] <= '0;
        st_q[i]   <= IDLE;
`ifdef MOVE_AUTOREPEAT_EN
        rcnt_q[i] <= '0;
`endif
      end
    end else begin
      s1_q     <= raw;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      pulse_q  <= pulse_d;
      for (int i = 0; i < NB; i++) begin
        dcnt_q[i] <= dcnt_d[i];
        st_q[i]   <= st_d[i];
`ifdef MOVE_AUTOREPEAT_EN
        rcnt_q[i] <= rcnt_d[i];
`endif
      end
    end
  end

  assign up       = pulse_q[0];
  assign down     = pulse_q[1];
  assign left     = pulse_q[2];
  assign right    = pulse_q[3];
  assign any_held = |stable_q;

endmodule
